// File: rtl/nin_vdata_sequencer_if.sv
// nin_vdata_sequencer_if: upstream pixel-pair ready/valid bundle.
// master = pixel source, slave = sequencer.
`timescale 1ns/1ps
interface nin_vdata_sequencer_if;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_y1;
    logic [7:0] pix_y2;
    logic [7:0] pix_cb;
    logic [7:0] pix_cr;

    modport master (
        output pix_valid,
        output pix_y1,
        output pix_y2,
        output pix_cb,
        output pix_cr,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_y1,
        input  pix_y2,
        input  pix_cb,
        input  pix_cr,
        output pix_ready
    );
endinterface

// File: rtl/nin_vdata_sequencer.sv
// nin_vdata_sequencer: raster timing and VData/CSel byte sequencer.
// Build option NINVID_INTERLACE_EN enables odd/even field tracking.
`timescale 1ns/1ps
module nin_vdata_sequencer #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 64,
    parameter int V_ACTIVE    = 480,
    parameter int V_BLANK     = 45,
    parameter int HSYNC_PIX   = 32,
    parameter int BURST_PIX   = 16,
    parameter int VSYNC_LINES = 3
) (
    input  logic                  VClock,
    input  logic                  VReset_n,
    input  logic                  en,
    input  logic                  non_interlaced,
    nin_vdata_sequencer_if.slave  pix,
    output logic [7:0]            VData,
    output logic                  CSel,
    output logic                  frame_start,
    output logic                  underflow
);
    localparam int HG = (H_ACTIVE + H_BLANK) / 2;
    localparam int VT = V_ACTIVE + V_BLANK;
    localparam int HW = $clog2(HG + 1);
    localparam int VW = $clog2(VT + 1);

    localparam logic [HW-1:0] H_LAST      = HW'(HG - 1);
    localparam logic [HW-1:0] H_ACT       = HW'(H_ACTIVE / 2);
    localparam logic [HW-1:0] H_ACT_LAST  = HW'(H_ACTIVE / 2 - 1);
    localparam logic [HW-1:0] H_SYNC_END  = HW'((H_ACTIVE + HSYNC_PIX) / 2);
    localparam logic [HW-1:0] H_BURST_END =
        HW'((H_ACTIVE + HSYNC_PIX + BURST_PIX) / 2);
    localparam logic [VW-1:0] V_LAST      = VW'(VT - 1);
    localparam logic [VW-1:0] V_ACT       = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(V_ACTIVE + VSYNC_LINES);

    // pair layout {Y1, Cb, Y2, Cr}
    localparam logic [31:0] BLANK_PAIR = 32'h1080_1080;

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

    state_t        state_q, state_d;
    logic [2:0]    slot_q, slot_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [31:0]   pair_q, pair_d;
    logic [7:0]    vdata_q, vdata_d;
    logic          csel_q, csel_d;
    logic          ready_q, ready_d;
    logic          fs_q, fs_d;
    logic          und_q, und_d;
    logic          en_q;
    logic          grp_end, line_end, frame_end;
    logic          hs, burst, vs, blank;
    logic          ni_d, odd_d;
    logic [7:0]    flags;

    assign grp_end   = (slot_q == 3'd4);
    assign line_end  = grp_end && (h_q == H_LAST);
    assign frame_end = line_end && (v_q == V_LAST);

    // State register
    always_ff @(posedge VClock or negedge VReset_n) begin
        if (!VReset_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next-state: state always names the kind of group being emitted
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en) state_d = ACTIVE;
            ACTIVE:  if (grp_end && h_q == H_ACT_LAST) state_d = HBLANK;
            HBLANK:  if (line_end) state_d = (v_d < V_ACT) ? ACTIVE : VBLANK;
            VBLANK:  if (frame_end) state_d = en ? ACTIVE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Raster counters advance one slot per cycle while running
    always_comb begin
        slot_d = slot_q;
        h_d    = h_q;
        v_d    = v_q;
        if (state_q != IDLE) begin
            slot_d = grp_end ? 3'd0 : slot_q + 3'd1;
            if (grp_end) h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
            if (line_end) v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    // Pair for slots 1-4 is latched at the end of slot 0
    always_comb begin
        pair_d = pair_q;
        if (state_q != IDLE && slot_q == 3'd0) begin
            pair_d = (ready_q && pix.pix_valid) ?
                {pix.pix_y1, pix.pix_cb, pix.pix_y2, pix.pix_cr} :
                BLANK_PAIR;
        end
    end

    assign fs_d = (state_d == ACTIVE) && (slot_d == 3'd0) &&
                  (h_d == '0) && (v_d == '0);

    // Starved active group sets the flag; a rising en clears it
    assign und_d = (und_q && !(en && !en_q)) || (ready_q && !pix.pix_valid);

`ifdef NINVID_INTERLACE_EN
    logic ni_q, odd_q;

    assign ni_d  = fs_d ? non_interlaced : ni_q;
    assign odd_d = fs_d ? (non_interlaced | ~odd_q) : odd_q;

    // Field mode and parity, updated at each frame start
    always_ff @(posedge VClock or negedge VReset_n) begin
        if (!VReset_n) begin
            ni_q  <= 1'b1;
            odd_q <= 1'b1;
        end else begin
            ni_q  <= ni_d;
            odd_q <= odd_d;
        end
    end
`else
    logic unused_ni;

    assign unused_ni = non_interlaced;
    assign ni_d      = 1'b1;
    assign odd_d     = 1'b1;
`endif

    assign blank = (state_d != ACTIVE);
    assign hs    = (h_d >= H_ACT) && (h_d < H_SYNC_END);
    assign burst = (h_d >= H_SYNC_END) && (h_d < H_BURST_END);
    assign vs    = (v_d >= V_ACT) && (v_d < V_SYNC_END);
    assign flags = {hs | vs, odd_d, vs, hs, burst, blank, 1'b0, ni_d};

    // Output decode for the slot about to be presented
    always_comb begin
        vdata_d = 8'h00;
        csel_d  = 1'b0;
        ready_d = 1'b0;
        if (state_d != IDLE) begin
            unique case (slot_d)
                3'd0: begin
                    vdata_d = flags;
                    csel_d  = 1'b1;
                    ready_d = (state_d == ACTIVE);
                end
                3'd1:    vdata_d = pair_d[31:24];
                3'd2:    vdata_d = pair_d[23:16];
                3'd3:    vdata_d = pair_d[15:8];
                3'd4:    vdata_d = pair_d[7:0];
                default: vdata_d = 8'h00;
            endcase
        end
    end

    // Raster position, captured pair and registered outputs
    always_ff @(posedge VClock or negedge VReset_n) begin
        if (!VReset_n) begin
            slot_q  <= '0;
            h_q     <= '0;
            v_q     <= '0;
            pair_q  <= BLANK_PAIR;
            vdata_q <= 8'h00;
            csel_q  <= 1'b0;
            ready_q <= 1'b0;
            fs_q    <= 1'b0;
            und_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            h_q     <= h_d;
            v_q     <= v_d;
            pair_q  <= pair_d;
            vdata_q <= vdata_d;
            csel_q  <= csel_d;
            ready_q <= ready_d;
            fs_q    <= fs_d;
            und_q   <= und_d;
            en_q    <= en;
        end
    end

    assign VData         = vdata_q;
    assign CSel          = csel_q;
    assign frame_start   = fs_q;
    assign underflow     = und_q;
    assign pix.pix_ready = ready_q;
endmodule

// File: tb/tb_nin_vdata_sequencer.sv
// tb_nin_vdata_sequencer: scoreboard bench for nin_vdata_sequencer.
// Raster 6 lines x 6 groups; honours NINVID_INTERLACE_EN when defined.
`timescale 1ns/1ps
module tb_nin_vdata_sequencer;
    typedef struct {
        int         cyc;
        logic [7:0] vd;
        logic       cs;
        logic       fs;
        logic       rdy;
        logic       und;
    } exp_t;

    localparam logic [31:0] BLANK = 32'h1080_1080;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       ni;
    logic [7:0] vdata;
    logic       csel;
    logic       fs;
    logic       und;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    bit          rst_v;
    bit          en_v;
    int          starve_frame = 2;
    bit          m_run;
    bit          m_en_prev;
    bit          m_und;
    bit          m_odd;
    bit          m_ni;
    int          m_l;
    int          m_g;
    int          m_s;
    int          m_frame;
    logic [31:0] m_pair;

    nin_vdata_sequencer_if pix();

    nin_vdata_sequencer #(
        .H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(4), .V_BLANK(2),
        .HSYNC_PIX(2), .BURST_PIX(2), .VSYNC_LINES(1)
    ) dut (
        .VClock(clk),
        .VReset_n(rst_n),
        .en(en),
        .non_interlaced(ni),
        .pix(pix),
        .VData(vdata),
        .CSel(csel),
        .frame_start(fs),
        .underflow(und)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int c,
                       input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, c, act, req);
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectation
    always @(negedge clk) begin : mon
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missed cyc=%0d got=none want=entry", e.cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            chk("vdata", cyc, vdata, e.vd);
            chk("csel", cyc, {7'd0, csel}, {7'd0, e.cs});
            chk("frame_start", cyc, {7'd0, fs}, {7'd0, e.fs});
            chk("pix_ready", cyc, {7'd0, pix.pix_ready}, {7'd0, e.rdy});
            chk("underflow", cyc, {7'd0, und}, {7'd0, e.und});
        end
    end

    function automatic logic [31:0] pair_for(int l, int g);
        if (l == 0 && g == 0) return {8'd67, 8'd131, 8'd67, 8'd147};
        return {8'(16 + l * 8 + g), 8'(128 + g * 5 + l),
                8'(200 - l * 3 - g), 8'(90 + g * 7)};
    endfunction

    // Hand-computed flags for progressive mode (b0=1, b6=1)
    function automatic logic [7:0] flags_for(int l, int g);
        logic [7:0] f;
        if (l < 4)       f = (g < 4) ? 8'h41 : (g == 4) ? 8'hD5 : 8'h4D;
        else if (l == 4) f = (g < 4) ? 8'hE5 : (g == 4) ? 8'hF5 : 8'hED;
        else             f = (g < 4) ? 8'h45 : (g == 4) ? 8'hD5 : 8'h4D;
`ifdef NINVID_INTERLACE_EN
        f = (f & 8'hBE) | {1'b0, m_odd, 5'b0, m_ni};
`endif
        return f;
    endfunction

    task automatic model_reset();
        m_run     = 1'b0;
        m_l       = 0;
        m_g       = 0;
        m_s       = 0;
        m_und     = 1'b0;
        m_en_prev = 1'b0;
        m_odd     = 1'b1;
        m_ni      = 1'b1;
        m_pair    = BLANK;
    endtask

    task automatic new_frame();
        m_frame++;
`ifdef NINVID_INTERLACE_EN
        m_ni  = ni;
        m_odd = ni ? 1'b1 : ~m_odd;
`endif
    endtask

    // One cycle: drive inputs, queue the expectation, advance the model
    task automatic tick();
        logic [31:0] d;
        bit          act;
        bit          v;
        bit          und_n;
        exp_t        e;
        @(posedge clk);
        #1;
        rst_n = rst_v;
        en    = en_v;
        if (!rst_v) model_reset();
        act = m_run && m_l < 4 && m_g < 4;
        if (m_run && m_s == 0) begin
            d = pair_for(m_l, m_g);
            v = !(m_frame == starve_frame && m_l == 1 && m_g == 2);
        end else begin
            d = 32'hEEEE_EEEE;
            v = 1'b1;
        end
        {pix.pix_y1, pix.pix_cb, pix.pix_y2, pix.pix_cr} = d;
        pix.pix_valid = v;
        e.cyc = cyc;
        e.vd  = 8'h00;
        e.cs  = 1'b0;
        e.fs  = 1'b0;
        e.rdy = 1'b0;
        e.und = m_und;
        if (m_run) begin
            if (m_s == 0) begin
                e.vd  = flags_for(m_l, m_g);
                e.cs  = 1'b1;
                e.rdy = act;
                e.fs  = (m_l == 0 && m_g == 0);
            end else begin
                e.vd = m_pair[8 * (4 - m_s) +: 8];
            end
        end
        exp_q.push_back(e);
        if (rst_v) begin
            und_n = m_und;
            if (en_v && !m_en_prev) und_n = 1'b0;
            if (act && m_s == 0 && !v) und_n = 1'b1;
            m_und = und_n;
            if (m_run && m_s == 0) m_pair = (act && v) ? d : BLANK;
            if (!m_run) begin
                if (en_v) begin
                    m_run = 1'b1;
                    m_l   = 0;
                    m_g   = 0;
                    m_s   = 0;
                    new_frame();
                end
            end else if (m_s < 4) begin
                m_s++;
            end else begin
                m_s = 0;
                if (m_g < 5) begin
                    m_g++;
                end else begin
                    m_g = 0;
                    if (m_l < 5) begin
                        m_l++;
                    end else begin
                        m_l = 0;
                        if (en_v) new_frame();
                        else m_run = 1'b0;
                    end
                end
            end
            m_en_prev = en_v;
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        en            = 1'b0;
        ni            = 1'b0;
        pix.pix_valid = 1'b0;
        pix.pix_y1    = 8'h00;
        pix.pix_y2    = 8'h00;
        pix.pix_cb    = 8'h00;
        pix.pix_cr    = 8'h00;
        rst_v         = 1'b0;
        en_v          = 1'b0;
        m_frame       = 0;
        model_reset();

        repeat (3) tick();
        rst_v = 1'b1;
        repeat (3) tick();

        en_v = 1'b1;
        for (int k = 0; k < 2000 && !(m_frame == 3 && m_l == 2); k++)
            tick();

        en_v = 1'b0;
        for (int k = 0; k < 2000 && m_run; k++) tick();
        repeat (20) tick();

        en_v = 1'b1;
        for (int k = 0; k < 2000 &&
             !(m_frame == 4 && m_l == 1 && m_g == 0 && m_s == 2); k++)
            tick();

        rst_v = 1'b0;
        repeat (2) tick();
        rst_v = 1'b1;
        repeat (40) tick();

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
